// File: rtl/despachante_copias.sv
// Copy-job dispatcher: queues operator copy requests, strobes each job to the
// copier, counts finished copies and supervises pauses and copier stalls.
module despachante_copias #(
   parameter int QTY_BITS   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                        clk_2,
   input  logic                        reset,
   input  logic                        job_valid,
   input  logic [QTY_BITS-1:0]         job_qty,
   input  logic                        clear_fault,
   input  logic                        copy_done,
   input  logic                        no_paper,
   input  logic                        jammed,
   output logic                        copiar,
   output logic [QTY_BITS-1:0]         quantidade,
   output logic                        busy,
   output logic                        paused,
   output logic                        fault,
   output logic                        job_done,
   output logic                        drop,
   output logic [$clog2(FIFO_DEPTH):0] fill,
   output logic [7:0]                  total,
   output logic [6:0]                  seg
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT);
   localparam logic [PTR_W:0]   FULL   = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PAUSED, FAULT} state_t;

   state_t              state, state_nx;
   logic [QTY_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [QTY_BITS-1:0] remaining, rem_nx;
   logic [WD_W-1:0]     watchdog, wd_nx;
   logic                accept, push, pop, count, done_nx, stall;

   function automatic logic [6:0] seg_of(input state_t s);
      case (s)
         ISSUE:   return 7'b0000110;
         WAIT:    return 7'b1011011;
         PAUSED:  return 7'b1001111;
         FAULT:   return 7'b1110001;
         default: return 7'b0111111;
      endcase
   endfunction

   // Full check uses occupancy before this cycle's pop
   assign accept = job_valid && (job_qty != '0);
   assign push   = accept && (fill != FULL);
   assign stall  = no_paper || jammed;

   always_comb begin
      state_nx = state;
      rem_nx   = remaining;
      wd_nx    = watchdog;
      pop      = 1'b0;
      count    = 1'b0;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (fill != '0) begin
               pop      = 1'b1;
               rem_nx   = mem[rd_ptr];
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            wd_nx    = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            if (copy_done) begin
               count  = 1'b1;
               rem_nx = remaining - QTY_BITS'(1);
               wd_nx  = '0;
               if (remaining == QTY_BITS'(1)) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else if (stall) begin
                  state_nx = PAUSED;
               end
            end else if (stall) begin
               state_nx = PAUSED;
            end else if (watchdog == WD_MAX) begin
               state_nx = FAULT;
            end else begin
               wd_nx = watchdog + WD_W'(1);
            end
         end
         PAUSED: begin
            // Watchdog stays frozen; late copies still count toward the job
            if (copy_done) begin
               count  = 1'b1;
               rem_nx = remaining - QTY_BITS'(1);
            end
            if (copy_done && remaining == QTY_BITS'(1)) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else if (!stall) begin
               state_nx = WAIT;
            end
         end
         FAULT: begin
            if (clear_fault) state_nx = ISSUE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk_2) begin
      if (push) mem[wr_ptr] <= job_qty;
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fill       <= '0;
         remaining  <= '0;
         watchdog   <= '0;
         total      <= '0;
         copiar     <= 1'b0;
         quantidade <= '0;
         busy       <= 1'b0;
         paused     <= 1'b0;
         fault      <= 1'b0;
         job_done   <= 1'b0;
         drop       <= 1'b0;
         seg        <= 7'b0111111;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fill <= fill + (PTR_W + 1)'(1);
            2'b01:   fill <= fill - (PTR_W + 1)'(1);
            default: fill <= fill;
         endcase
         remaining <= rem_nx;
         watchdog  <= wd_nx;
         if (count) total <= total + 8'd1;
         // The strobe is launched from ISSUE, so it is seen during the first WAIT cycle
         copiar <= (state == ISSUE);
         if (state == ISSUE) quantidade <= remaining;
         busy     <= (state_nx != IDLE);
         paused   <= (state_nx == PAUSED);
         fault    <= (state_nx == FAULT);
         job_done <= done_nx;
         drop     <= accept && (fill == FULL);
         seg      <= seg_of(state_nx);
      end
   end
endmodule

// File: doc/despachante_copias.md
# despachante_copias

Copy-job dispatcher: the initiator side of the copier handshake. It queues operator copy requests, issues each job to the copier as a one-cycle `copiar` strobe with a quantity, and counts finished copies from the copier's per-copy strobe. It pauses while the copier reports missing paper or a jam, and raises a fault if the copier stalls. It sits between the board switches and the copier FSM; status goes to LEDs and a 7-segment digit.

## Interface
Parameters:
- `QTY_BITS`, 2: width of a job quantity.
- `FIFO_DEPTH`, 4: job queue entries (power of 2).
- `TIMEOUT`, 15: idle cycles allowed in WAIT before FAULT.

Ports:
- `clk_2` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high; clock clk_2.
- `job_valid` in 1: enqueue request, sampled every rising edge.
- `job_qty` in QTY_BITS: copies requested with `job_valid`.
- `clear_fault` in 1: leave FAULT and reissue the job.
- `copy_done` in 1: copier strobe, one cycle per finished copy.
- `no_paper` in 1: copier level, paper missing.
- `jammed` in 1: copier level, paper jam.
- `copiar` out 1: registered one-cycle job strobe to the copier.
- `quantidade` out QTY_BITS: job quantity; valid while `copiar`=1, holds its value otherwise.
- `busy` out 1: state is not IDLE.
- `paused` out 1: state is PAUSED.
- `fault` out 1: state is FAULT.
- `job_done` out 1: one-cycle pulse when a job completes.
- `drop` out 1: one-cycle pulse when a request is rejected.
- `fill` out $clog2(FIFO_DEPTH)+1: queue occupancy.
- `total` out 8: finished-copy counter; wraps 255→0.
- `seg` out 7: state digit.

## Operation
- Queue (FIFO):
  - Push when `job_valid`=1, `job_qty`≠0 and `fill`<FIFO_DEPTH.
  - `job_qty`=0 is ignored silently.
  - Push while full is discarded and pulses `drop`.
  - The full check uses `fill` before any pop in the same cycle, so push and pop in one cycle while full still drops.
- State machine, register `remaining`, and watchdog:
  - IDLE: if queue is non-empty, pop the head into `remaining` and go to ISSUE.
  - ISSUE: `copiar`=1 and `quantidade`=`remaining` for exactly this cycle. Clear the watchdog. Go to WAIT.
  - WAIT, on `copy_done`:
    - `remaining`−1, `total`+1, clear the watchdog.
    - If `remaining` reaches 0: pulse `job_done` and go to IDLE.
  - WAIT, on `no_paper` or `jammed`: go to PAUSED.
    - If `copy_done` arrives in the same cycle, count it first.
    - If that count completes the job, go to IDLE; completion has priority.
  - WAIT, otherwise: watchdog+1. When the watchdog reaches TIMEOUT, go to FAULT.
  - PAUSED:
    - Watchdog is frozen.
    - `copy_done` is still counted; if that completes the job, go to IDLE.
    - When `no_paper`=0 and `jammed`=0, return to WAIT with no reissue (the copier resumes on its own).
  - FAULT: hold until `clear_fault`=1, then go to ISSUE, reissuing the current `remaining`. The queue keeps accepting jobs.
- `seg` patterns:
  - IDLE 0111111
  - ISSUE 0000110
  - WAIT 1011011
  - PAUSED 1001111
  - FAULT 1110001
- Reset mid-operation: the queue, the job in flight, and all counters are discarded.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `copiar` 0, `quantidade` 0, `busy` 0, `paused` 0, `fault` 0, `job_done` 0, `drop` 0, `fill` 0, `total` 0, `seg` 0111111, `remaining` 0, watchdog 0.
- Latency, empty queue and IDLE: push at edge N, pop at edge N+1, `copiar` high for the cycle after edge N+2.
- Back-to-back jobs: `job_done` at edge M, next pop at M+1, next `copiar` after M+2.
- FAULT is entered on the edge where the watchdog equals TIMEOUT, i.e. TIMEOUT+1 WAIT cycles with no `copy_done`.

## Test plan
- Reset, then one job `job_qty`=2, then two `copy_done` pulses → `copiar`=1 exactly once with `quantidade`=2, then `job_done` pulse, `total`=2, IDLE, `seg`=0111111.
- Push 5 jobs of qty 1 while `copy_done` is held 0 → the 1st job is popped and issued. Pushes 2–5 fill the queue: after the 5th push `fill`=4 and no `drop` yet. A 6th push → `drop` pulse, `fill` stays 4.
- Mid-job `jammed`=1 for 10 cycles → PAUSED, `seg`=1001111, no FAULT. Release `jammed` → WAIT with no second `copiar`. Remaining `copy_done` pulses complete the job.
- Job qty 3, one `copy_done`, then silence → FAULT after 16 cycles, `fault`=1. Pulse `clear_fault` → `copiar` with `quantidade`=2.
- Single-copy job with `copy_done` and `no_paper` both high in the same cycle → `job_done` pulses, IDLE, PAUSED not entered.
- Assert `reset` while in WAIT with 2 queued jobs → all outputs at reset values immediately, `fill`=0, `total`=0.
